cpu_data_responder: RTL and testbench

- Memory-side responder for the CPU core's MEM-stage data port.
- Consumes the core's single-cycle request view: mem_en, mem_we, sel, mem_size, address, write data.
- Drives a split-phase sram-like bus (req/addr_ok/data_ok), returns read data to the core and holds the pipeline through stallreq_from_mem until the access completes.
- Handles exception flush of an in-flight access by draining it silently.

---
 rtl/cpu_data_responder.sv | 171 +++++++++++++++++
 tb/tb_cpu_data_responder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_data_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cpu_data_responder                                           |
// | Description : MEM-stage data port responder onto a split-phase sram-like   |
// |               bus (req/addr_ok/data_ok) with stall and flush-drain logic.  |
// |               Define DATA_RESP_BYPASS_EN to return read data in the        |
// |               data_ok cycle instead of one cycle later.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cpu_data_responder #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_en,
    input  logic                mem_we,
    input  logic [DATA_W/8-1:0] sel,
    input  logic [1:0]          mem_size,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_flush,
    input  logic                cpu_stall,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                stallreq_from_mem,
    output logic                data_req,
    output logic                data_wr,
    output logic [1:0]          data_size,
    output logic [ADDR_W-1:0]   data_addr,
    output logic [DATA_W/8-1:0] data_wstrb,
    output logic [DATA_W-1:0]   data_wdata,
    input  logic                data_addr_ok,
    input  logic                data_data_ok,
    input  logic [DATA_W-1:0]   data_rdata
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_DATA  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_addr_pend;
    logic                  w_addr_pend_nxt;
    logic                  r_we;
    logic [1:0]            r_size;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W/8-1:0]   r_wstrb;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W-1:0]     r_rdata;
    logic                  w_issue;
    logic                  w_latch;
    logic                  w_capture;

    assign w_issue = mem_en & ~mem_flush;

    always_comb begin
        w_state_nxt       = r_state;
        w_addr_pend_nxt   = r_addr_pend;
        w_latch           = 1'b0;
        w_capture         = 1'b0;
        data_req          = 1'b0;
        stallreq_from_mem = 1'b0;
        mem_rdata         = r_rdata;
        data_wr           = r_we;
        data_size         = r_size;
        data_addr         = r_addr;
        data_wstrb        = r_wstrb;
        data_wdata        = r_wdata;
        case (r_state)
            S_IDLE: begin
                // Request goes out in the same cycle the core presents it
                data_req          = w_issue;
                stallreq_from_mem = w_issue;
                data_wr           = mem_we;
                data_size         = mem_size;
                data_addr         = mem_addr;
                data_wstrb        = sel;
                data_wdata        = mem_wdata;
                if (w_issue) begin
                    w_latch     = 1'b1;
                    w_state_nxt = data_addr_ok ? S_DATA : S_ADDR;
                end
            end
            S_ADDR: begin
                data_req          = 1'b1;
                stallreq_from_mem = ~mem_flush;
                if (mem_flush) begin
                    w_state_nxt     = S_DRAIN;
                    w_addr_pend_nxt = ~data_addr_ok;
                end else if (data_addr_ok) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                stallreq_from_mem = ~mem_flush;
                if (mem_flush) begin
                    w_state_nxt     = data_data_ok ? S_IDLE : S_DRAIN;
                    w_addr_pend_nxt = 1'b0;
                end else if (data_data_ok) begin
                    w_capture = ~r_we;
`ifdef DATA_RESP_BYPASS_EN
                    stallreq_from_mem = 1'b0;
                    if (!r_we) begin
                        mem_rdata = data_rdata;
                    end
                    w_state_nxt = cpu_stall ? S_DONE : S_IDLE;
`else
                    w_state_nxt = S_DONE;
`endif
                end
            end
            S_DONE: begin
                if (!cpu_stall) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                // The aborted access keeps its handshake; only a new request stalls
                data_req          = r_addr_pend;
                stallreq_from_mem = w_issue;
                if (r_addr_pend) begin
                    if (data_addr_ok) begin
                        w_addr_pend_nxt = 1'b0;
                    end
                end else if (data_data_ok) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (!rst) begin
            data_req          = 1'b0;
            stallreq_from_mem = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_addr_pend <= 1'b0;
            r_we        <= 1'b0;
            r_size      <= 2'd0;
            r_addr      <= '0;
            r_wstrb     <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr_pend <= w_addr_pend_nxt;
            if (w_latch) begin
                r_we    <= mem_we;
                r_size  <= mem_size;
                r_addr  <= mem_addr;
                r_wstrb <= sel;
                r_wdata <= mem_wdata;
            end
            if (w_capture) begin
                r_rdata <= data_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_data_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cpu_data_responder                                        |
// | Description : Cycle-vector bench for cpu_data_responder; honours           |
// |               DATA_RESP_BYPASS_EN when it is defined for the build.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_cpu_data_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_en = 1'b0;
    logic        mem_we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [1:0]  mem_size = 2'd0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic        mem_flush = 1'b0;
    logic        cpu_stall = 1'b0;
    logic [31:0] mem_rdata;
    logic        stallreq_from_mem;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic [31:0] data_rdata = 32'h0;

    cpu_data_responder #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_en            (mem_en),
        .mem_we            (mem_we),
        .sel               (sel),
        .mem_size          (mem_size),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_flush         (mem_flush),
        .cpu_stall         (cpu_stall),
        .mem_rdata         (mem_rdata),
        .stallreq_from_mem (stallreq_from_mem),
        .data_req          (data_req),
        .data_wr           (data_wr),
        .data_size         (data_size),
        .data_addr         (data_addr),
        .data_wstrb        (data_wstrb),
        .data_wdata        (data_wdata),
        .data_addr_ok      (data_addr_ok),
        .data_data_ok      (data_data_ok),
        .data_rdata        (data_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic        we;
        logic [3:0]  sel;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        flush;
        logic        cst;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
        logic        e_req;
        logic        e_stall;
        logic [31:0] e_rdata;
        logic        e_wr;
        logic [1:0]  e_size;
        logic [31:0] e_addr;
        logic [3:0]  e_wstrb;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t vecs[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Core-side request currently presented, and the payload the bus should carry
    logic        c_we;
    logic [3:0]  c_sel;
    logic [1:0]  c_size;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic        p_we;
    logic [3:0]  p_sel;
    logic [1:0]  p_size;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;

    task set_core(input logic we, input logic [3:0] s, input logic [1:0] sz,
                  input logic [31:0] a, input logic [31:0] wd);
        c_we = we; c_sel = s; c_size = sz; c_addr = a; c_wdata = wd;
    endtask

    task pay();
        p_we = c_we; p_sel = c_sel; p_size = c_size; p_addr = c_addr; p_wdata = c_wdata;
    endtask

    task add(input logic en, input logic fl, input logic cs, input logic aok,
             input logic dok, input logic [31:0] rd, input logic e_req,
             input logic e_stall, input logic [31:0] e_rdata);
        vec_t v;
        v.en = en; v.we = c_we; v.sel = c_sel; v.size = c_size; v.addr = c_addr;
        v.wdata = c_wdata; v.flush = fl; v.cst = cs; v.aok = aok; v.dok = dok;
        v.rdata = rd; v.e_req = e_req; v.e_stall = e_stall; v.e_rdata = e_rdata;
        v.e_wr = p_we; v.e_size = p_size; v.e_addr = p_addr; v.e_wstrb = p_sel;
        v.e_wdata = p_wdata;
        vecs.push_back(v);
    endtask

    task chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row=%0d actual=%h required=%h", name, row, act, exp);
        end
    endtask

    task drive(input vec_t v);
        mem_en = v.en; mem_we = v.we; sel = v.sel; mem_size = v.size;
        mem_addr = v.addr; mem_wdata = v.wdata; mem_flush = v.flush;
        cpu_stall = v.cst; data_addr_ok = v.aok; data_data_ok = v.dok;
        data_rdata = v.rdata;
    endtask

    task build_table();
`ifndef DATA_RESP_BYPASS_EN
        // Load on a zero-wait bus, then core held in DONE
        set_core(1'b0, 4'hF, 2'd2, 32'h1000_0004, 32'h0); pay();
        add(1, 0, 0, 1, 0, 32'h0,         1, 1, 32'h0);
        add(1, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 1, 32'h0);
        repeat (5) add(1, 0, 1, 0, 0, 32'h0, 0, 0, 32'hDEAD_BEEF);
        add(1, 0, 0, 0, 0, 32'h0,         0, 0, 32'hDEAD_BEEF);
        // Store, addr_ok after 3 wait cycles; core inputs disturbed meanwhile
        set_core(1'b1, 4'h3, 2'd1, 32'h1000_0010, 32'h0000_ABCD); pay();
        add(1, 0, 0, 0, 0, 32'h0,         1, 1, 32'hDEAD_BEEF);
        set_core(1'b1, 4'hF, 2'd2, 32'hFFFF_FFFC, 32'h1111_1111);
        add(1, 0, 0, 0, 0, 32'h0,         1, 1, 32'hDEAD_BEEF);
        add(1, 0, 0, 0, 0, 32'h0,         1, 1, 32'hDEAD_BEEF);
        add(1, 0, 0, 1, 0, 32'h0,         1, 1, 32'hDEAD_BEEF);
        add(1, 0, 0, 0, 0, 32'h0,         0, 1, 32'hDEAD_BEEF);
        add(1, 0, 0, 0, 1, 32'h5555_5555, 0, 1, 32'hDEAD_BEEF);
        add(1, 0, 0, 0, 0, 32'h0,         0, 0, 32'hDEAD_BEEF);
        // Flush in DATA
        set_core(1'b0, 4'hF, 2'd2, 32'h1000_0020, 32'h0); pay();
        add(1, 0, 0, 1, 0, 32'h0,         1, 1, 32'hDEAD_BEEF);
        add(1, 1, 0, 0, 0, 32'h0,         0, 0, 32'hDEAD_BEEF);
        add(0, 0, 0, 0, 1, 32'h1234_5678, 0, 0, 32'hDEAD_BEEF);
        add(0, 0, 0, 0, 0, 32'h0,         0, 0, 32'hDEAD_BEEF);
        // Flush in ADDR (accepted same cycle), new load waits out the drain
        set_core(1'b0, 4'hF, 2'd2, 32'h1000_0030, 32'h0); pay();
        add(1, 0, 0, 0, 0, 32'h0,         1, 1, 32'hDEAD_BEEF);
        add(1, 1, 0, 1, 0, 32'h0,         1, 0, 32'hDEAD_BEEF);
        set_core(1'b0, 4'hF, 2'd2, 32'h1000_0040, 32'h0);
        add(1, 0, 0, 0, 0, 32'h0,         0, 1, 32'hDEAD_BEEF);
        add(1, 0, 0, 0, 1, 32'hAAAA_AAAA, 0, 1, 32'hDEAD_BEEF);
        pay();
        add(1, 0, 0, 1, 0, 32'h0,         1, 1, 32'hDEAD_BEEF);
        add(1, 0, 0, 0, 1, 32'hCAFE_F00D, 0, 1, 32'hDEAD_BEEF);
        add(1, 0, 0, 0, 0, 32'h0,         0, 0, 32'hCAFE_F00D);
        // Flush with addr_ok still pending: drain covers both phases
        set_core(1'b0, 4'hF, 2'd2, 32'h1000_0050, 32'h0); pay();
        add(1, 0, 0, 0, 0, 32'h0,         1, 1, 32'hCAFE_F00D);
        add(1, 1, 0, 0, 0, 32'h0,         1, 0, 32'hCAFE_F00D);
        add(0, 0, 0, 0, 0, 32'h0,         1, 0, 32'hCAFE_F00D);
        add(0, 0, 0, 1, 0, 32'h0,         1, 0, 32'hCAFE_F00D);
        add(0, 0, 0, 0, 1, 32'hBAD0_BAD0, 0, 0, 32'hCAFE_F00D);
        // Flush coincident with data_ok
        set_core(1'b0, 4'hF, 2'd2, 32'h1000_0060, 32'h0); pay();
        add(1, 0, 0, 1, 0, 32'h0,         1, 1, 32'hCAFE_F00D);
        add(1, 1, 0, 0, 1, 32'h0BAD_F00D, 0, 0, 32'hCAFE_F00D);
        add(0, 0, 0, 0, 0, 32'h0,         0, 0, 32'hCAFE_F00D);
        // Flush in IDLE issues nothing; the next load proves IDLE was kept
        add(1, 1, 0, 1, 0, 32'h0,         0, 0, 32'hCAFE_F00D);
        add(0, 0, 0, 0, 0, 32'h0,         0, 0, 32'hCAFE_F00D);
        set_core(1'b0, 4'hC, 2'd1, 32'h1000_0072, 32'h0); pay();
        add(1, 0, 0, 1, 0, 32'h0,         1, 1, 32'hCAFE_F00D);
        add(1, 0, 0, 0, 1, 32'h0042_0000, 0, 1, 32'hCAFE_F00D);
        add(0, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0042_0000);
`else
        set_core(1'b0, 4'hF, 2'd2, 32'h1000_0004, 32'h0); pay();
        add(1, 0, 0, 1, 0, 32'h0,         1, 1, 32'h0);
        add(1, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF);
        add(0, 0, 0, 0, 0, 32'h0,         0, 0, 32'hDEAD_BEEF);
        set_core(1'b0, 4'hF, 2'd2, 32'h1000_0008, 32'h0); pay();
        add(1, 0, 0, 1, 0, 32'h0,         1, 1, 32'hDEAD_BEEF);
        add(1, 0, 1, 0, 1, 32'h1234_5678, 0, 0, 32'h1234_5678);
        add(1, 0, 1, 0, 0, 32'h0,         0, 0, 32'h1234_5678);
        add(1, 0, 0, 0, 0, 32'h0,         0, 0, 32'h1234_5678);
        set_core(1'b0, 4'hF, 2'd2, 32'h1000_000C, 32'h0); pay();
        add(1, 0, 0, 1, 0, 32'h0,         1, 1, 32'h1234_5678);
        add(1, 1, 0, 0, 1, 32'h9999_9999, 0, 0, 32'h1234_5678);
        add(0, 0, 0, 0, 0, 32'h0,         0, 0, 32'h1234_5678);
`endif
    endtask

    initial begin
        vec_t z;
        z = '0;
        build_table();

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_req",   -1, {31'd0, data_req},          32'd0);
        chk("reset_stall", -1, {31'd0, stallreq_from_mem}, 32'd0);
        chk("reset_rdata", -1, mem_rdata,                  32'd0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            @(negedge clk);
            chk("req",   i, {31'd0, data_req},          {31'd0, vecs[i].e_req});
            chk("stall", i, {31'd0, stallreq_from_mem}, {31'd0, vecs[i].e_stall});
            chk("rdata", i, mem_rdata,                  vecs[i].e_rdata);
            if (vecs[i].e_req) begin
                chk("wr",    i, {31'd0, data_wr},    {31'd0, vecs[i].e_wr});
                chk("size",  i, {30'd0, data_size},  {30'd0, vecs[i].e_size});
                chk("addr",  i, data_addr,           vecs[i].e_addr);
                chk("wstrb", i, {28'd0, data_wstrb}, {28'd0, vecs[i].e_wstrb});
                chk("wdata", i, data_wdata,          vecs[i].e_wdata);
            end
        end

        // Asynchronous reset in the middle of DATA with the core still requesting
        @(posedge clk);
        #1;
        drive(z);
        mem_en = 1'b1; sel = 4'hF; mem_size = 2'd2; mem_addr = 32'h1000_0080;
        data_addr_ok = 1'b1;
        @(posedge clk);
        #1;
        data_addr_ok = 1'b0;
        @(negedge clk);
        chk("rstseq_data_req",   -2, {31'd0, data_req},          32'd0);
        chk("rstseq_data_stall", -2, {31'd0, stallreq_from_mem}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("rstseq_async_req",   -2, {31'd0, data_req},          32'd0);
        chk("rstseq_async_stall", -2, {31'd0, stallreq_from_mem}, 32'd0);
        chk("rstseq_async_rdata", -2, mem_rdata,                  32'd0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(negedge clk);
        chk("rstseq_idle_req",   -2, {31'd0, data_req},          32'd1);
        chk("rstseq_idle_stall", -2, {31'd0, stallreq_from_mem}, 32'd1);
        chk("rstseq_idle_addr",  -2, data_addr,                  32'h1000_0080);
        @(posedge clk);
        #1;
        drive(z);
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
